// File: rtl/fifo_burst_out.sv
// fifo_burst_out: output FIFO that releases stored words downstream in
// fixed-length bursts over a valid/ready handshake. A flush releases a
// partial burst; writes attempted while full are dropped and reported.
module fifo_burst_out #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C     = CW'(BURST_LEN);
  localparam logic [BW-1:0] BURST_REM_C = BW'(BURST_LEN);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BW-1:0]           burst_rem;
  logic [BW-1:0]           burst_rem_next;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    wr;
  logic                    rd;

  // Status flags all come from the registered count, so din_ready never
  // depends combinationally on dout_ready.
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign din_ready = !full;

  assign wr = din_valid & !full;
  assign rd = dout_valid & dout_ready;

  // Output side is driven purely from registered state; dout is zeroed
  // outside a burst so downstream never sees stale memory contents.
  assign dout_valid = (state == DRAIN);
  assign dout_last  = dout_valid && (burst_rem == BW'(1));
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  // Occupancy after this cycle's write/read; also steers burst launch.
  always_comb begin
    count_next = count_q + {{(CW-1){1'b0}}, wr} - {{(CW-1){1'b0}}, rd};
  end

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Control registers: FSM state, burst length, pointers, count, overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      burst_rem <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      burst_rem <= burst_rem_next;
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q  <= count_next;
      overflow <= din_valid & full;
    end
  end

  // Burst FSM: launch a full burst as soon as enough words are present
  // (looking at count_next so the launching write already counts), or a
  // partial one on flush; return to FILL after the last-word handshake.
  always_comb begin
    state_next     = state;
    burst_rem_next = burst_rem;
    case (state)
      FILL: begin
        if (count_next >= BURST_C) begin
          state_next     = DRAIN;
          burst_rem_next = BURST_REM_C;
        end else if (flush && (count_next != '0)) begin
          // count_next < BURST_LEN here, so it fits in burst_rem.
          state_next     = DRAIN;
          burst_rem_next = count_next[BW-1:0];
        end
      end
      DRAIN: begin
        if (rd) begin
          burst_rem_next = burst_rem - BW'(1);
          if (dout_last) begin
            state_next = FILL;
          end
        end
      end
      default: begin
        state_next     = FILL;
        burst_rem_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_burst_out.sv
// tb_fifo_burst_out: directed bench for fifo_burst_out (default build and a
// BURST_LEN=1 / DEPTH=4 / DATA_WIDTH=8 build sharing clock and reset).
module tb_fifo_burst_out;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        flush;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  logic [7:0]  b_din;
  logic        b_din_valid;
  logic        b_din_ready;
  logic        b_flush;
  logic [7:0]  b_dout;
  logic        b_dout_valid;
  logic        b_dout_ready;
  logic        b_dout_last;
  logic [2:0]  b_count;
  logic        b_full;
  logic        b_empty;
  logic        b_overflow;

  int n_checks = 0;
  int n_errors = 0;

  fifo_burst_out #(.DATA_WIDTH(32), .DEPTH(16), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  fifo_burst_out #(.DATA_WIDTH(8), .DEPTH(4), .BURST_LEN(1)) dut_b (
    .clk(clk), .rst(rst),
    .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .flush(b_flush),
    .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .dout_last(b_dout_last),
    .count(b_count), .full(b_full), .empty(b_empty), .overflow(b_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    int          exp_cnt;
    int          k;
    int          ovf;
    int          got_n;
    int          gaps;
    logic        w;
    logic        r;
    logic        prev_stall;
    logic [31:0] prev_dout;

    rst = 1'b1; din = '0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
    b_din = '0; b_din_valid = 1'b0; b_flush = 1'b0; b_dout_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    // ---- reset values
    check("rst_count", 64'(count), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full", 64'(full), 0);
    check("rst_din_ready", 64'(din_ready), 1);
    check("rst_dout_valid", 64'(dout_valid), 0);
    check("rst_dout_last", 64'(dout_last), 0);
    check("rst_dout", 64'(dout), 0);
    check("rst_overflow", 64'(overflow), 0);

    // ---- basic 4-word burst
    for (int i = 0; i < 4; i++) begin
      din = 32'hA0 + 32'(i); din_valid = 1'b1;
      step();
      if (i == 2) check("t1_no_valid_early", 64'(dout_valid), 0);
    end
    din_valid = 1'b0;
    check("t1_valid_at_n", 64'(dout_valid), 1);
    check("t1_count4", 64'(count), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_data", 64'(dout), 64'(32'hA0 + 32'(i)));
      check("t1_last", 64'(dout_last), (i == 3) ? 1 : 0);
      step();
    end
    check("t1_valid_off", 64'(dout_valid), 0);
    check("t1_empty", 64'(empty), 1);

    // ---- flush of a partial burst
    din = 32'h11; din_valid = 1'b1; step();
    din = 32'h22; step();
    din_valid = 1'b0;
    check("t2_count2", 64'(count), 2);
    check("t2_no_valid", 64'(dout_valid), 0);
    flush = 1'b1; step(); flush = 1'b0;
    check("t2_valid", 64'(dout_valid), 1);
    check("t2_d0", 64'(dout), 32'h11);
    check("t2_l0", 64'(dout_last), 0);
    step();
    check("t2_d1", 64'(dout), 32'h22);
    check("t2_l1", 64'(dout_last), 1);
    step();
    check("t2_done", 64'(dout_valid), 0);
    flush = 1'b1; step(); flush = 1'b0;
    check("t2_empty_flush", 64'(dout_valid), 0);
    step();
    check("t2_empty_flush2", 64'(dout_valid), 0);

    // ---- fill to full with stalled output, overflow, then drain
    dout_ready = 1'b0; ovf = 0;
    for (int i = 0; i < 18; i++) begin
      din = 32'h100 + 32'(i); din_valid = 1'b1;
      step();
      ovf += int'(overflow);
      if (i == 15) begin
        check("t3_full", 64'(full), 1);
        check("t3_din_ready", 64'(din_ready), 0);
      end
    end
    din_valid = 1'b0;
    step();
    ovf += int'(overflow);
    check("t3_ovf_pulses", 64'(ovf), 2);
    check("t3_ovf_clear", 64'(overflow), 0);
    check("t3_count16", 64'(count), 16);
    check("t3_hold_valid", 64'(dout_valid), 1);
    check("t3_hold_data", 64'(dout), 32'h100);
    dout_ready = 1'b1; got_n = 0; gaps = 0;
    for (int c = 0; c < 40 && got_n < 16; c++) begin
      if (dout_valid) begin
        check("t3_data", 64'(dout), 64'(32'h100 + 32'(got_n)));
        check("t3_last", 64'(dout_last), ((got_n % 4) == 3) ? 1 : 0);
        got_n++;
      end else begin
        gaps++;
      end
      step();
    end
    check("t3_words", 64'(got_n), 16);
    check("t3_gaps", 64'(gaps), 3);
    check("t3_empty", 64'(empty), 1);

    // ---- random ready toggling with concurrent writes, then flush-drain
    exp_cnt = 0; k = 0; prev_stall = 1'b0; prev_dout = '0;
    for (int c = 0; c < 100; c++) begin
      if (c < 60) begin
        din_valid  = 1'($urandom_range(0, 1));
        dout_ready = 1'($urandom_range(0, 1));
        flush      = 1'b0;
      end else begin
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        flush      = 1'b1;
      end
      din = 32'h200 + 32'(k);
      if (prev_stall) begin
        check("t4_stall_valid", 64'(dout_valid), 1);
        check("t4_stall_data", 64'(dout), 64'(prev_dout));
      end
      if (dout_valid) begin
        if (q.size() == 0) check("t4_underrun", 64'(dout_valid), 0);
        else check("t4_data", 64'(dout), 64'(q[0]));
      end
      w = din_valid && din_ready;
      r = dout_valid && dout_ready;
      if (w) begin
        q.push_back(din);
        k++;
      end
      if (r && q.size() > 0) void'(q.pop_front());
      exp_cnt = exp_cnt + int'(w) - int'(r);
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      step();
      check("t4_count", 64'(count), 64'(exp_cnt));
    end
    flush = 1'b0; dout_ready = 1'b1;
    check("t4_all_drained", 64'(q.size()), 0);
    check("t4_empty", 64'(empty), 1);

    // ---- reset in the middle of a burst
    for (int i = 0; i < 4; i++) begin
      din = 32'h30 + 32'(i); din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    check("t5_valid", 64'(dout_valid), 1);
    step(); step();
    check("t5_mid", 64'(dout), 32'h32);
    rst = 1'b1; step(); rst = 1'b0;
    check("t5_count", 64'(count), 0);
    check("t5_valid_off", 64'(dout_valid), 0);
    check("t5_dout0", 64'(dout), 0);
    check("t5_empty", 64'(empty), 1);
    for (int i = 0; i < 4; i++) begin
      din = 32'h55; din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    check("t5_new_valid", 64'(dout_valid), 1);
    check("t5_new_data", 64'(dout), 32'h55);
    check("t5_new_count", 64'(count), 4);
    for (int i = 0; i < 4; i++) step();
    check("t5_new_empty", 64'(empty), 1);

    // ---- BURST_LEN=1 build: every word is its own burst
    b_din = 8'h5A; b_din_valid = 1'b1; step(); b_din_valid = 1'b0;
    check("b_valid", 64'(b_dout_valid), 1);
    check("b_data", 64'(b_dout), 8'h5A);
    check("b_last", 64'(b_dout_last), 1);
    check("b_count1", 64'(b_count), 1);
    step();
    check("b_done", 64'(b_dout_valid), 0);
    b_din = 8'h01; b_din_valid = 1'b1; step();
    check("b_v1", 64'(b_dout_valid), 1);
    check("b_d1", 64'(b_dout), 8'h01);
    check("b_l1", 64'(b_dout_last), 1);
    b_din = 8'h02; step(); b_din_valid = 1'b0;
    check("b_gap", 64'(b_dout_valid), 0);
    check("b_gap_count", 64'(b_count), 1);
    step();
    check("b_v2", 64'(b_dout_valid), 1);
    check("b_d2", 64'(b_dout), 8'h02);
    check("b_l2", 64'(b_dout_last), 1);
    step();
    check("b_end_valid", 64'(b_dout_valid), 0);
    check("b_end_empty", 64'(b_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
